i2s_fifo_n: RTL and testbench

Parametrised synchronous FIFO for the APB I2S TX and RX paths. It replaces the fixed 4-entry buffer and adds four features: configurable depth, level reporting, programmable almost-empty/almost-full watermarks for interrupt generation, and sticky overflow/underflow error flags. It sits between the APB register interface and the I2S serialiser/deserialiser, and both sides run on a single clock domain.

---
 rtl/i2s_fifo_n.sv | 111 +++++++++++
 tb/tb_i2s_fifo_n.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_fifo_n.sv
// Parametrised I2S TX/RX FIFO with level, watermarks and sticky error flags; write-to-read latency 1 cycle.
// Backpressure: data_in_ack drops while full or flushing, and pops are ignored while empty.
module i2s_fifo_n #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_reset,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              data_in_valid,
    output logic              data_in_ack,
    output logic [WIDTH-1:0]  data_out,
    output logic              data_out_valid,
    input  logic              data_out_ack,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   fifo_level,
    output logic [ADDR_W:0]   fifo_space,
    input  logic [ADDR_W:0]   ae_thresh,
    input  logic [ADDR_W:0]   af_thresh,
    output logic              almost_empty,
    output logic              almost_full,
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic [ADDR_W:0]  level;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic             unf_set;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign level      = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                        (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    assign fifo_level   = level;
    assign fifo_space   = DEPTH_V - level;
    assign almost_empty = (level <= ae_thresh);
    assign almost_full  = (level >= af_thresh);

    assign data_in_ack    = data_in_valid & ~fifo_full & ~fifo_reset;
    assign data_out_valid = ~fifo_empty;
    assign data_out       = mem[rd_ptr[ADDR_W-1:0]];

    assign push    = data_in_ack;
    assign pop     = data_out_valid & data_out_ack & ~fifo_reset;
    assign ovf_set = data_in_valid & fifo_full & ~fifo_reset;
    assign unf_set = data_out_ack & fifo_empty & ~fifo_reset;

    // Storage survives a flush; only the async reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (fifo_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A set event in the same cycle as err_clr keeps the flag high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (fifo_reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_fifo_n.sv
// Scoreboard bench for i2s_fifo_n: a queue-based model tracks contents and flags, a negedge monitor compares.
module tb_i2s_fifo_n;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fifo_reset;
    logic [WIDTH-1:0]  data_in;
    logic              data_in_valid;
    logic              data_in_ack;
    logic [WIDTH-1:0]  data_out;
    logic              data_out_valid;
    logic              data_out_ack;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W:0]   fifo_level;
    logic [ADDR_W:0]   fifo_space;
    logic [ADDR_W:0]   ae_thresh;
    logic [ADDR_W:0]   af_thresh;
    logic              almost_empty;
    logic              almost_full;
    logic              err_clr;
    logic              overflow;
    logic              underflow;

    i2s_fifo_n #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_reset    (fifo_reset),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ack   (data_in_ack),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ack  (data_out_ack),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_level    (fifo_level),
        .fifo_space    (fifo_space),
        .ae_thresh     (ae_thresh),
        .af_thresh     (af_thresh),
        .almost_empty  (almost_empty),
        .almost_full   (almost_full),
        .err_clr       (err_clr),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue, flags follow the set/clear rules.
    always @(posedge clk) begin
        if (rst_n) begin
            if (fifo_reset) begin
                m_q.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                bit was_full;
                bit was_empty;
                was_full  = (m_q.size() == DEPTH);
                was_empty = (m_q.size() == 0);
                if (data_out_ack && !was_empty) void'(m_q.pop_front());
                if (data_in_valid && !was_full) m_q.push_back(data_in);
                if (data_in_valid && was_full) m_ovf = 1'b1;
                else if (err_clr) m_ovf = 1'b0;
                if (data_out_ack && was_empty) m_unf = 1'b1;
                else if (err_clr) m_unf = 1'b0;
            end
        end
    end

    always @(negedge rst_n) begin
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    end

    task automatic check_all();
        int lvl;
        lvl = m_q.size();
        chk("level", 32'(fifo_level), 32'(lvl));
        chk("space", 32'(fifo_space), 32'(DEPTH - lvl));
        chk("full", 32'(fifo_full), 32'(lvl == DEPTH));
        chk("empty", 32'(fifo_empty), 32'(lvl == 0));
        chk("out_valid", 32'(data_out_valid), 32'(lvl != 0));
        chk("almost_empty", 32'(almost_empty), 32'(lvl <= int'(ae_thresh)));
        chk("almost_full", 32'(almost_full), 32'(lvl >= int'(af_thresh)));
        chk("in_ack", 32'(data_in_ack), 32'(data_in_valid && lvl < DEPTH && !fifo_reset));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        if (lvl != 0) chk("data_out", data_out, m_q[0]);
    endtask

    // Monitor: compares every cycle away from the active edge.
    always @(negedge clk) check_all();

    task automatic cyc(input bit vld, input logic [31:0] dat, input bit ack,
                       input bit frst, input bit eclr);
        data_in_valid = vld;
        data_in       = dat;
        data_out_ack  = ack;
        fifo_reset    = frst;
        err_clr       = eclr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        fifo_reset = 1'b0; data_in = '0; data_in_valid = 1'b0;
        data_out_ack = 1'b0; err_clr = 1'b0;
        ae_thresh = 4'd2; af_thresh = 4'd6;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle();

        // Reset / idle
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_space", 32'(fifo_space), 32'd8);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_almost_full", 32'(almost_full), 32'd0);

        // Fill and drain
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 32'h1000_0000 + i, 1'b0, 1'b0, 1'b0);
            if (i == 5) chk("af_at_6", 32'(almost_full), 32'd1);
        end
        chk("fill_full", 32'(fifo_full), 32'd1);
        cyc(1'b1, 32'hdead_beef, 1'b0, 1'b0, 1'b0);
        chk("ninth_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            data_in_valid = 1'b0;
            #1 chk("drain_order", data_out, 32'h1000_0000 + i);
            cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", 32'(fifo_empty), 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("extra_pop_unf", 32'(underflow), 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Wrap at level 3
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h2000_0000 + i, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        idle();
        chk("wrap_level", 32'(fifo_level), 32'd3);
        chk("wrap_no_ovf", 32'(overflow), 32'd0);
        chk("wrap_no_unf", 32'(underflow), 32'd0);

        // Full plus simultaneous push/pop
        for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        chk("pre_full", 32'(fifo_full), 32'd1);
        cyc(1'b1, 32'h3333_3333, 1'b1, 1'b0, 1'b0);
        chk("full_pp_level", 32'(fifo_level), 32'd7);
        chk("full_pp_ovf", 32'(overflow), 32'd1);

        // Flush priority at level 5 with overflow set
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("pre_flush_level", 32'(fifo_level), 32'd5);
        data_in_valid = 1'b1; data_out_ack = 1'b1; fifo_reset = 1'b1;
        #1 chk("flush_no_ack", 32'(data_in_ack), 32'd0);
        cyc(1'b1, 32'h4444_4444, 1'b1, 1'b1, 1'b0);
        chk("flush_level", 32'(fifo_level), 32'd0);
        chk("flush_ovf", 32'(overflow), 32'd0);
        cyc(1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
        chk("post_flush_write", 32'(fifo_level), 32'd1);

        // Error clear race
        for (int i = 0; i < 7; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h6666_6666, 1'b0, 1'b0, 1'b1);
        chk("clr_race_ovf", 32'(overflow), 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("clr_alone_ovf", 32'(overflow), 32'd0);

        // Randomised traffic with changing watermarks
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 16) == 0) begin
                ae_thresh = 4'($urandom_range(0, 10));
                af_thresh = 4'($urandom_range(0, 10));
            end
            cyc(1'($urandom), $urandom, 1'($urandom % 3 != 0),
                1'(($urandom % 50) == 0), 1'(($urandom % 20) == 0));
        end
        ae_thresh = 4'd2; af_thresh = 4'd6;

        // Async reset mid-stream
        for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(fifo_level), 32'd0);
        chk("arst_empty", 32'(fifo_empty), 32'd1);
        chk("arst_valid", 32'(data_out_valid), 32'd0);
        chk("arst_data_out", data_out, 32'h0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        data_in_valid = 1'b0; data_out_ack = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b1, 32'h7777_7777, 1'b0, 1'b0, 1'b0);
        chk("arst_first_write", 32'(fifo_level), 32'd1);
        chk("arst_first_data", data_out, 32'h7777_7777);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
